stage_sequencer: RTL and testbench

//  Multi-cycle controller for the single-issue LEGv8 datapath. Replaces the fixed

---
 rtl/stage_sequencer_pkg.sv | 44 ++++
 rtl/stage_sequencer_if.sv | 38 +++
 rtl/stage_sequencer_mem_wait_timer.sv | 24 ++
 rtl/stage_sequencer.sv | 89 ++++++++
 tb/tb_stage_sequencer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/stage_sequencer_pkg.sv
// Shared state encodings, stage-enable bundle and the state -> enable decode
// for the LEGv8 multi-cycle stage sequencer.
package stage_sequencer_pkg;

  localparam int ST_W = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_MEMORY    = 3'd4,
    ST_WRITEBACK = 3'd5,
    ST_FAULT     = 3'd6
  } state_e;

  typedef struct packed {
    logic fetch_en;
    logic decode_en;
    logic exec_en;
    logic mem_req;
    logic wb_en;
    logic pc_write;
  } stage_en_t;

  // Pure Moore decode; acc is the access flag captured when MEMORY is entered.
  function automatic stage_en_t stage_enables(state_e s, logic acc);
    stage_en_t e;
    e = '0;
    case (s)
      ST_FETCH:     e.fetch_en  = 1'b1;
      ST_DECODE:    e.decode_en = 1'b1;
      ST_EXECUTE:   e.exec_en   = 1'b1;
      ST_MEMORY:    e.mem_req   = acc;
      ST_WRITEBACK: begin
        e.wb_en    = 1'b1;
        e.pc_write = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/stage_sequencer_if.sv
// Control/handshake bundle between the stage sequencer (master) and the
// datapath / data-memory side (slave).
interface stage_sequencer_if #(
  parameter int CNT_W = 32
);
  import stage_sequencer_pkg::*;

  logic             run;
  logic             halt_req;
  logic             mem_read;
  logic             mem_write;
  logic             reg_write;
  logic             mem_ready;
  logic             fetch_en;
  logic             decode_en;
  logic             exec_en;
  logic             mem_req;
  logic             wb_en;
  logic             rf_write_en;
  logic             pc_write;
  logic             busy;
  logic             mem_fault;
  logic [CNT_W-1:0] instr_count;
  logic [ST_W-1:0]  state;

  modport master (
    input  run, halt_req, mem_read, mem_write, reg_write, mem_ready,
    output fetch_en, decode_en, exec_en, mem_req, wb_en, rf_write_en,
           pc_write, busy, mem_fault, instr_count, state
  );

  modport slave (
    output run, halt_req, mem_read, mem_write, reg_write, mem_ready,
    input  fetch_en, decode_en, exec_en, mem_req, wb_en, rf_write_en,
           pc_write, busy, mem_fault, instr_count, state
  );

endinterface

// File: rtl/stage_sequencer_mem_wait_timer.sv
// Counts memory-phase cycles spent without mem_ready; expired flags the
// MEM_TIMEOUT-th such cycle so the sequencer faults on the next edge.
module stage_sequencer_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] cnt_q;

  assign expired = en && (cnt_q == W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) cnt_q <= '0;
    else if (en && !expired) cnt_q <= cnt_q + W'(1);
  end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/write-back sequencer: one-hot stage
// enables from a single clock, memory-ready stretching, halt latch, retire count.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  stage_sequencer_if.master bus
);

  state_e           state_q, state_d;
  logic             acc_q;
  logic             halt_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy;
  logic             tmr_clear, tmr_en, tmr_expired;
  stage_en_t        en;

  assign busy = (state_q != ST_IDLE) && (state_q != ST_FAULT);

  stage_sequencer_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (tmr_clear),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  // Timer is idle-cleared outside MEMORY so every memory phase starts at zero.
  assign tmr_clear = (state_q != ST_MEMORY);
  assign tmr_en    = (state_q == ST_MEMORY) && acc_q && !bus.mem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      acc_q   <= 1'b0;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_EXECUTE) acc_q <= bus.mem_read | bus.mem_write;
      // Halt is consumed at write-back whether it was latched or arrives there.
      if (state_q == ST_WRITEBACK) halt_q <= 1'b0;
      else if (busy && bus.halt_req) halt_q <= 1'b1;
      if ((state_q == ST_WRITEBACK) && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (bus.run) state_d = ST_FETCH;
      ST_FETCH:     state_d = ST_DECODE;
      ST_DECODE:    state_d = ST_EXECUTE;
      ST_EXECUTE:   state_d = ST_MEMORY;
      ST_MEMORY: begin
        if (!acc_q || bus.mem_ready) state_d = ST_WRITEBACK;
        else if (tmr_expired)        state_d = ST_FAULT;
      end
      ST_WRITEBACK: begin
        if (halt_q || bus.halt_req) state_d = ST_IDLE;
        else if (bus.run)           state_d = ST_FETCH;
        else                        state_d = ST_IDLE;
      end
      ST_FAULT:     state_d = ST_FAULT;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Strobes are squashed while reset is asserted so an aborted instruction
  // never commits a register or PC write.
  assign en = reset ? '0 : stage_enables(state_q, acc_q);

  assign bus.fetch_en    = en.fetch_en;
  assign bus.decode_en   = en.decode_en;
  assign bus.exec_en     = en.exec_en;
  assign bus.mem_req     = en.mem_req;
  assign bus.wb_en       = en.wb_en;
  assign bus.pc_write    = en.pc_write;
  assign bus.rf_write_en = en.wb_en & bus.reg_write;
  assign bus.busy        = busy;
  assign bus.mem_fault   = (state_q == ST_FAULT);
  assign bus.instr_count = cnt_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed scoreboard bench for stage_sequencer: stimulus pushes per-cycle
// expectations, a negedge monitor pops and compares.
module tb_stage_sequencer;

  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2,
                         S_EXECUTE = 3'd3, S_MEMORY = 3'd4, S_WB = 3'd5,
                         S_FAULT = 3'd6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  stage_sequencer_if #(.CNT_W(4)) bus ();

  stage_sequencer #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    logic [2:0] st;
    logic [8:0] outs;
    logic [3:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // outs = {fetch, decode, exec, mem_req, wb, rf_we, pc_write, busy, mem_fault}
  function automatic logic [8:0] mk(logic [2:0] s, logic mreq, logic rf);
    logic busy;
    busy = (s != S_IDLE) && (s != S_FAULT);
    return {s == S_FETCH, s == S_DECODE, s == S_EXECUTE, mreq, s == S_WB,
            rf, s == S_WB, busy, s == S_FAULT};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic want_raw(input string nm, input logic [2:0] s, input logic [8:0] o,
                          input logic [3:0] c);
    exp_t e;
    e.name = nm; e.st = s; e.outs = o; e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic want(input string nm, input logic [2:0] s, input logic mreq,
                      input logic rf, input logic [3:0] c);
    want_raw(nm, s, mk(s, mreq, rf), c);
  endtask

  exp_t       m_e;
  logic [8:0] m_act;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m_e   = sb.pop_front();
      m_act = {bus.fetch_en, bus.decode_en, bus.exec_en, bus.mem_req, bus.wb_en,
               bus.rf_write_en, bus.pc_write, bus.busy, bus.mem_fault};
      vectors++;
      if (m_act !== m_e.outs || bus.state !== m_e.st || bus.instr_count !== m_e.cnt) begin
        miscompares++;
        $display("FAIL %s @%0t: state=%0d outs=%b cnt=%0d, expected state=%0d outs=%b cnt=%0d",
                 m_e.name, $time, bus.state, m_act, bus.instr_count, m_e.st, m_e.outs, m_e.cnt);
      end
    end
  end

  task automatic do_reset();
    tick(); reset = 1'b1;
    tick(); reset = 1'b1;
    want("reset", S_IDLE, 1'b0, 1'b0, 4'd0);
    tick(); reset = 1'b0; bus.run = 1'b0; bus.halt_req = 1'b0; bus.mem_read = 1'b0;
    bus.mem_write = 1'b0; bus.reg_write = 1'b0; bus.mem_ready = 1'b0;
    want("reset_release", S_IDLE, 1'b0, 1'b0, 4'd0);
  endtask

  task automatic start(input logic [3:0] c);
    tick(); bus.run = 1'b1;
    want("idle_run", S_IDLE, 1'b0, 1'b0, c);
  endtask

  // late < 0: mem_ready never arrives, stop after the full timeout window.
  task automatic run_instr(input logic [3:0] c0, input logic rd, input logic wr,
                           input logic rw, input int late, input logic run_wb,
                           input logic halt_d);
    logic acc;
    acc = rd | wr;
    tick(); bus.reg_write = rw; bus.mem_ready = 1'b0; bus.halt_req = 1'b0;
    want("fetch", S_FETCH, 1'b0, 1'b0, c0);
    tick(); bus.halt_req = halt_d; bus.mem_ready = acc && (late != 0);
    want("decode", S_DECODE, 1'b0, 1'b0, c0);
    tick(); bus.halt_req = 1'b0; bus.mem_read = rd; bus.mem_write = wr;
    want("execute", S_EXECUTE, 1'b0, 1'b0, c0);
    if (!acc) begin
      tick(); bus.mem_ready = 1'b0;
      want("mem_none", S_MEMORY, 1'b0, 1'b0, c0);
    end else if (late < 0) begin
      repeat (15) begin
        tick(); bus.mem_ready = 1'b0;
        want("mem_timeout_wait", S_MEMORY, 1'b1, 1'b0, c0);
      end
      return;
    end else begin
      for (int k = 0; k <= late; k++) begin
        tick(); bus.mem_ready = (k == late);
        want("mem_wait", S_MEMORY, 1'b1, 1'b0, c0);
      end
    end
    tick(); bus.mem_ready = 1'b0; bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    bus.run = run_wb;
    want("writeback", S_WB, 1'b0, rw, c0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; bus.run = 1'b1; bus.halt_req = 1'b0; bus.mem_read = 1'b0;
    bus.mem_write = 1'b0; bus.reg_write = 1'b0; bus.mem_ready = 1'b0;

    // Reset held two cycles with run=1, then three back-to-back ALU instructions.
    tick(); reset = 1'b1;
    want("rst_hold", S_IDLE, 1'b0, 1'b0, 4'd0);
    tick(); reset = 1'b0; bus.run = 1'b1; bus.reg_write = 1'b1;
    want("rst_hold", S_IDLE, 1'b0, 1'b0, 4'd0);
    run_instr(4'd0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    run_instr(4'd1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    run_instr(4'd2, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0);
    tick(); want("alu_idle", S_IDLE, 1'b0, 1'b0, 4'd3);

    // Load with ready 3 cycles late; then ready 14 late (last cycle before timeout).
    do_reset();
    start(4'd0);
    run_instr(4'd0, 1'b1, 1'b0, 1'b1, 3, 1'b0, 1'b0);
    tick(); want("load_idle", S_IDLE, 1'b0, 1'b0, 4'd1);
    start(4'd1);
    run_instr(4'd1, 1'b1, 1'b0, 1'b0, 14, 1'b0, 1'b0);
    tick(); want("load14_idle", S_IDLE, 1'b0, 1'b0, 4'd2);

    // Store that never gets ready: fault is sticky until reset.
    do_reset();
    start(4'd0);
    run_instr(4'd0, 1'b0, 1'b1, 1'b1, -1, 1'b1, 1'b0);
    repeat (3) begin
      tick(); bus.run = 1'b1; bus.mem_ready = 1'b1;
      want("fault", S_FAULT, 1'b0, 1'b0, 4'd0);
    end

    // Halt pulse during DECODE, then read+write together with zero-wait ready.
    do_reset();
    start(4'd0);
    run_instr(4'd0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b1);
    tick(); bus.run = 1'b1;
    want("halt_idle", S_IDLE, 1'b0, 1'b0, 4'd1);
    run_instr(4'd1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    tick(); want("rdwr_idle", S_IDLE, 1'b0, 1'b0, 4'd2);

    // Reset during MEMORY aborts the instruction and zeroes the count.
    do_reset();
    start(4'd0);
    run_instr(4'd0, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0);
    tick(); want("abort_fetch", S_FETCH, 1'b0, 1'b0, 4'd1);
    tick(); want("abort_decode", S_DECODE, 1'b0, 1'b0, 4'd1);
    tick(); bus.mem_write = 1'b1;
    want("abort_exec", S_EXECUTE, 1'b0, 1'b0, 4'd1);
    tick(); bus.mem_ready = 1'b0;
    want("abort_mem", S_MEMORY, 1'b1, 1'b0, 4'd1);
    tick(); reset = 1'b1;
    want_raw("abort_reset_mem", S_MEMORY, 9'b0_0000_0010, 4'd1);
    tick(); reset = 1'b0; bus.run = 1'b0; bus.mem_write = 1'b0;
    want("abort_idle", S_IDLE, 1'b0, 1'b0, 4'd0);
    tick(); want("abort_idle2", S_IDLE, 1'b0, 1'b0, 4'd0);

    // 17 instructions into a 4-bit counter: saturates at 15.
    do_reset();
    start(4'd0);
    for (int i = 0; i < 17; i++) begin
      run_instr((i > 15) ? 4'd15 : 4'(i), 1'b0, 1'b0, 1'(i % 2), 0, (i != 16), 1'b0);
    end
    tick(); want("sat_idle", S_IDLE, 1'b0, 1'b0, 4'd15);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
